// File: rtl/instr_fetch_queue.sv
// Fetch stage: sequences the PC, issues word fetches to a synchronous instruction
// memory and buffers returned instruction/PC pairs for decode behind a valid/ready handshake.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [31:0]                id_instr,
    output logic [31:0]                id_pc,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   pc_q;
    logic [31:0]   req_pc_q;
    logic          inflight;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW:0]   credit;
    logic          push;
    logic          pop;

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];

    // A fetch is only issued if its response is guaranteed a free slot, counting the one in flight.
    assign credit    = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign imem_req  = rst_n & ~redirect_valid & (credit < DEPTH_C);
    assign imem_addr = pc_q;

    assign push = inflight & ~redirect_valid;
    assign pop  = id_valid & id_ready & ~redirect_valid;

    assign id_valid  = (count != '0);
    assign id_instr  = instr_mem[rd_ptr];
    assign id_pc     = pc_mem[rd_ptr];
    assign occupancy = count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= {RESET_PC[31:2], 2'b00};
            req_pc_q <= '0;
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (redirect_valid) begin
            // Squash everything younger than the redirect, including the in-flight word.
            pc_q     <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (imem_req) begin
                pc_q     <= pc_q + 32'd4;
                req_pc_q <= pc_q;
                inflight <= 1'b1;
            end else begin
                inflight <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            instr_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]    <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: directed scenarios push expected PC/instruction
// pairs; a negedge monitor pops and compares every accepted decode handshake.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [2:0]  occupancy;

    int          checks = 0;
    int          errors = 0;
    int          bad_req = 0;
    int          bad_before;
    logic [63:0] exp_q[$];

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    // Synchronous memory: word = address | A000_0000, garbage when not requested.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (imem_addr | 32'hA000_0000) : 32'hDEAD_BEEF;
        if (rst_n && imem_req && imem_addr == 32'h0000_0200) bad_req++;
    end

    // Every accepted handshake must match the oldest expected entry.
    always @(negedge clk) begin
        logic [63:0] exp;
        if (rst_n === 1'b1 && id_valid === 1'b1 && id_ready === 1'b1 && redirect_valid === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pop: got pc %h instr %h, required no delivery", id_pc, id_instr);
            end else begin
                exp = exp_q.pop_front();
                if ({id_pc, id_instr} !== exp)begin
                    errors++;
                    $display("[TB] FAIL delivery: got pc %h instr %h, required pc %h instr %h",
                             id_pc, id_instr, exp[63:32], exp[31:0]);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, required %h", name, $time, actual, expected);
        end
    endtask

    task automatic push_expected(input logic [31:0] pc);
        exp_q.push_back({pc, pc | 32'hA000_0000});
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        next_cycle();
        next_cycle();
        #2;
        check_output("reset_id_valid", {31'b0, id_valid}, 32'h0);
        check_output("reset_imem_req", {31'b0, imem_req}, 32'h0);
        check_output("reset_occupancy", {29'b0, occupancy}, 32'h0);
        check_output("reset_imem_addr", imem_addr, 32'h0);
        exp_q.delete();
    endtask

    // Keep id_ready high until every expected entry has been delivered, then stall.
    task automatic drain(input string name);
        id_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            next_cycle();
            if (exp_q.size() == 0) begin
                id_ready = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s_drain: got %0d entries pending, required 0", name, exp_q.size());
        exp_q.delete();
        id_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Scenario 1: streaming from reset with decode always ready.
        apply_reset();
        next_cycle();
        rst_n    = 1'b1;
        id_ready = 1'b1;
        for (int p = 0; p <= 20; p += 4) push_expected(p);
        #2;
        check_output("s1_addr_c0", imem_addr, 32'h0);
        check_output("s1_req_c0", {31'b0, imem_req}, 32'h1);
        check_output("s1_valid_c0", {31'b0, id_valid}, 32'h0);
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            #2;
            check_output("s1_addr", imem_addr, 32'(4 * c));
            check_output("s1_req", {31'b0, imem_req}, 32'h1);
            check_output("s1_valid", {31'b0, id_valid}, (c >= 2) ? 32'h1 : 32'h0);
            if (c == 2) begin
                check_output("s1_first_pc", id_pc, 32'h0);
                check_output("s1_first_instr", id_instr, 32'hA000_0000);
            end
        end
        drain("s1");

        // Scenario 2: decode stalled for 10 cycles, queue saturates then drains in order.
        apply_reset();
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) next_cycle();
            #2;
            check_output("s2_occupancy", {29'b0, occupancy}, (c < 2) ? 32'h0 : ((c >= 5) ? 32'h4 : 32'(c - 1)));
            check_output("s2_req", {31'b0, imem_req}, (c <= 3) ? 32'h1 : 32'h0);
            if (c >= 2) begin
                check_output("s2_stall_pc", id_pc, 32'h0);
                check_output("s2_stall_instr", id_instr, 32'hA000_0000);
            end
        end
        next_cycle();
        for (int p = 0; p <= 20; p += 4) push_expected(p);
        id_ready = 1'b1;
        next_cycle();
        #2;
        check_output("s2_resume_addr", imem_addr, 32'h10);
        check_output("s2_resume_req", {31'b0, imem_req}, 32'h1);
        drain("s2");

        // Scenario 3: redirect with 3 entries queued and one fetch in flight.
        apply_reset();
        next_cycle();
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #2;
        check_output("s3_pre_occupancy", {29'b0, occupancy}, 32'h3);
        check_output("s3_req_in_r", {31'b0, imem_req}, 32'h0);
        next_cycle();
        redirect_valid = 1'b0;
        #2;
        check_output("s3_occ_r1", {29'b0, occupancy}, 32'h0);
        check_output("s3_addr_r1", imem_addr, 32'h0000_0100);
        check_output("s3_req_r1", {31'b0, imem_req}, 32'h1);
        next_cycle();
        #2;
        check_output("s3_valid_r2", {31'b0, id_valid}, 32'h0);
        next_cycle();
        push_expected(32'h100);
        push_expected(32'h104);
        push_expected(32'h108);
        #2;
        check_output("s3_valid_r3", {31'b0, id_valid}, 32'h1);
        check_output("s3_pc_r3", id_pc, 32'h0000_0100);
        drain("s3");

        // Scenario 4: redirect during a handshake, then a second redirect which must win.
        apply_reset();
        bad_before = bad_req;
        next_cycle();
        rst_n    = 1'b1;
        id_ready = 1'b1;
        push_expected(32'h0);
        next_cycle();
        next_cycle();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #2;
        check_output("s4_handshake_valid", {31'b0, id_valid}, 32'h1);
        check_output("s4_req_r1", {31'b0, imem_req}, 32'h0);
        next_cycle();
        redirect_pc = 32'h0000_0040;
        #2;
        check_output("s4_req_r2", {31'b0, imem_req}, 32'h0);
        check_output("s4_occ_r2", {29'b0, occupancy}, 32'h0);
        next_cycle();
        redirect_valid = 1'b0;
        push_expected(32'h40);
        push_expected(32'h44);
        push_expected(32'h48);
        #2;
        check_output("s4_addr", imem_addr, 32'h0000_0040);
        next_cycle();
        #2;
        check_output("s4_valid_early", {31'b0, id_valid}, 32'h0);
        next_cycle();
        #2;
        check_output("s4_pc", id_pc, 32'h0000_0040);
        drain("s4");
        check_output("s4_first_target_fetches", 32'(bad_req - bad_before), 32'h0);

        // Scenario 5: PC wraps past 2^32.
        apply_reset();
        next_cycle();
        rst_n          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        #2;
        check_output("s5_req_r", {31'b0, imem_req}, 32'h0);
        next_cycle();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        push_expected(32'hFFFF_FFF8);
        push_expected(32'hFFFF_FFFC);
        push_expected(32'h0000_0000);
        push_expected(32'h0000_0004);
        #2;
        check_output("s5_addr1", imem_addr, 32'hFFFF_FFF8);
        next_cycle();
        #2;
        check_output("s5_addr2", imem_addr, 32'hFFFF_FFFC);
        next_cycle();
        #2;
        check_output("s5_addr3", imem_addr, 32'h0000_0000);
        check_output("s5_pc3", id_pc, 32'hFFFF_FFF8);
        drain("s5");

        // Scenario 6: one-cycle reset pulse in the middle of a stream.
        apply_reset();
        next_cycle();
        rst_n    = 1'b1;
        id_ready = 1'b1;
        for (int p = 0; p <= 12; p += 4) push_expected(p);
        for (int p = 0; p <= 8; p += 4) push_expected(p);
        for (int c = 1; c <= 5; c++) next_cycle();
        next_cycle();
        rst_n = 1'b0;
        #2;
        check_output("s6_req_in_reset", {31'b0, imem_req}, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        #2;
        check_output("s6_valid_after", {31'b0, id_valid}, 32'h0);
        check_output("s6_occ_after", {29'b0, occupancy}, 32'h0);
        check_output("s6_addr_after", imem_addr, 32'h0);
        next_cycle();
        #2;
        check_output("s6_valid_c1", {31'b0, id_valid}, 32'h0);
        next_cycle();
        #2;
        check_output("s6_valid_c2", {31'b0, id_valid}, 32'h1);
        check_output("s6_pc_c2", id_pc, 32'h0);
        drain("s6");

        next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
